// File: rtl/sum_display_driver_if.sv
// ============================================================================
// sum_display_driver_if : load/value handshake and display pins of the driver
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sum_display_driver_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic              load;
  logic [WIDTH-1:0]  value;
  logic              busy;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;

  modport master (output load, value, input busy, an, seg);
  modport slave  (input load, value, output busy, an, seg);
endinterface

`default_nettype wire

// File: rtl/sum_display_driver.sv
// ============================================================================
// sum_display_driver : captures a binary sum, converts it to BCD one bit per
// clock, and scans it onto a common-anode 7-segment display.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sum_display_driver #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sum_display_driver_if.slave  bus
);

  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_REF_W = $clog2(REFRESH_DIV);
  localparam int c_BCD_W = 4 * DIGITS;

  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DIGITS - 1);
  localparam logic [c_REF_W-1:0] c_LAST_REF = c_REF_W'(REFRESH_DIV - 1);
  localparam logic [DIGITS-1:0]  c_AN_RST   = ~(DIGITS'(1));
  localparam logic [6:0]         c_SEG_ZERO = 7'b1000000;
  localparam logic [6:0]         c_SEG_BLNK = 7'b1111111;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_CONVERT = 1'b1
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_bin;
  logic [c_BCD_W-1:0]   r_bcd;
  logic [c_CNT_W-1:0]   r_bit_cnt;
  logic [c_BCD_W-1:0]   r_digits;
  logic [c_REF_W-1:0]   r_ref_cnt;
  logic [c_IDX_W-1:0]   r_scan_idx;
  logic [DIGITS-1:0]    r_an;
  logic [6:0]           r_seg;

  logic [c_BCD_W-1:0]   w_bcd_next;
  logic [3:0]           w_nib_adj;
  logic                 w_carry;
  logic                 w_nz;
  logic [DIGITS-1:0]    w_blank;
  logic [3:0]           w_nib;
  logic                 w_sel_blank;
  logic [DIGITS-1:0]    w_an_next;
  logic [6:0]           w_seg_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = c_SEG_BLNK;
    endcase
  endfunction

  // Add-3 then shift: each nibble's adjusted MSB carries into the next nibble's LSB.
  always_comb begin
    w_bcd_next = '0;
    w_nib_adj  = '0;
    w_carry    = r_bin[WIDTH-1];
    for (int k = 0; k < DIGITS; k++) begin
      w_nib_adj = r_bcd[4*k +: 4];
      if (w_nib_adj >= 4'd5) w_nib_adj = w_nib_adj + 4'd3;
      w_bcd_next[4*k +: 4] = {w_nib_adj[2:0], w_carry};
      w_carry = w_nib_adj[3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_bit_cnt <= '0;
      r_digits  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_bin     <= bus.value;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_bcd     <= w_bcd_next;
          r_bin     <= {r_bin[WIDTH-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == c_LAST_BIT) begin
            r_digits <= w_bcd_next;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Leading-zero blanking walks from the most significant digit down.
  always_comb begin
    w_nz        = 1'b0;
    w_blank     = '0;
    w_nib       = '0;
    w_sel_blank = 1'b0;
    w_an_next   = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_nz       = w_nz | (r_digits[4*k +: 4] != 4'd0);
      w_blank[k] = (k != 0) && !w_nz;
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (r_scan_idx == c_IDX_W'(k)) begin
        w_nib        = r_digits[4*k +: 4];
        w_sel_blank  = w_blank[k];
        w_an_next[k] = 1'b0;
      end
    end
    w_seg_next = w_sel_blank ? c_SEG_BLNK : seg_decode(w_nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_cnt  <= '0;
      r_scan_idx <= '0;
      r_an       <= c_AN_RST;
      r_seg      <= c_SEG_ZERO;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      if (r_ref_cnt == c_LAST_REF) begin
        r_ref_cnt  <= '0;
        r_scan_idx <= (r_scan_idx == c_LAST_IDX) ? '0 : r_scan_idx + 1'b1;
      end else begin
        r_ref_cnt <= r_ref_cnt + 1'b1;
      end
    end
  end

  assign bus.busy = (r_state == S_CONVERT);
  assign bus.an   = r_an;
  assign bus.seg  = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_sum_display_driver.sv
// ============================================================================
// tb_sum_display_driver : directed-vector bench for sum_display_driver
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sum_display_driver;

  localparam int WIDTH       = 8;
  localparam int DIGITS      = 3;
  localparam int REFRESH_DIV = 4;

  localparam logic [6:0] c_SEG0  = 7'b1000000;
  localparam logic [6:0] c_SEG1  = 7'b1111001;
  localparam logic [6:0] c_SEG2  = 7'b0100100;
  localparam logic [6:0] c_SEG5  = 7'b0010010;
  localparam logic [6:0] c_SEG7  = 7'b1111000;
  localparam logic [6:0] c_SEG9  = 7'b0010000;
  localparam logic [6:0] c_BLANK = 7'b1111111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc;

  always #5 clk = ~clk;

  sum_display_driver_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  sum_display_driver #(
    .WIDTH       (WIDTH),
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    bus.value = v;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    bus.value = 8'hA5;
  endtask

  // Runs until busy drops, checking the old picture stays on the pins meanwhile.
  task automatic wait_idle(input string tag, input logic [6:0] h0, input logic [6:0] h1,
                           input logic [6:0] h2, output int cycles);
    int hold_bad;
    hold_bad = 0;
    cycles   = 0;
    while (bus.busy === 1'b1 && cycles < 100) begin
      case (bus.an)
        3'b110:  if (bus.seg !== h0) hold_bad++;
        3'b101:  if (bus.seg !== h1) hold_bad++;
        3'b011:  if (bus.seg !== h2) hold_bad++;
        default: hold_bad++;
      endcase
      cycles++;
      @(negedge clk);
    end
    check({tag, "_hold"}, hold_bad, 0);
    check({tag, "_done"}, 32'(cycles < 100), 1);
  endtask

  task automatic check_display(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2);
    logic [6:0] s0, s1, s2;
    int bad_an;
    s0 = 7'b1010101;
    s1 = 7'b1010101;
    s2 = 7'b1010101;
    bad_an = 0;
    repeat (3 * REFRESH_DIV) begin
      @(negedge clk);
      case (bus.an)
        3'b110:  s0 = bus.seg;
        3'b101:  s1 = bus.seg;
        3'b011:  s2 = bus.seg;
        default: bad_an++;
      endcase
    end
    check({tag, "_d0"}, s0, e0);
    check({tag, "_d1"}, s1, e1);
    check({tag, "_d2"}, s2, e2);
    check({tag, "_an"}, bad_an, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.load  = 1'b0;
    bus.value = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_an", bus.an, 3'b110);
    check("rst_seg", bus.seg, c_SEG0);
    rst_n = 1'b1;

    // Idle scan: each digit lit for REFRESH_DIV clocks
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (i == 1)  begin check("t1_an_a", bus.an, 3'b110); check("t1_seg_a", bus.seg, c_SEG0);  end
      if (i == 4)  check("t1_an_hold", bus.an, 3'b110);
      if (i == 5)  begin check("t1_an_b", bus.an, 3'b101); check("t1_seg_b", bus.seg, c_BLANK); end
      if (i == 9)  begin check("t1_an_c", bus.an, 3'b011); check("t1_seg_c", bus.seg, c_BLANK); end
      if (i == 13) check("t1_an_wrap", bus.an, 3'b110);
    end

    // 255
    do_load(8'd255);
    check("t2_busy_rise", bus.busy, 1);
    wait_idle("t2", c_SEG0, c_BLANK, c_BLANK, cyc);
    check("t2_busy_cycles", cyc, 8);
    check_display("t2", c_SEG5, c_SEG5, c_SEG2);

    // 7 after 255
    do_load(8'd7);
    wait_idle("t3", c_SEG5, c_SEG5, c_SEG2, cyc);
    check("t3_busy_cycles", cyc, 8);
    check_display("t3", c_SEG7, c_BLANK, c_BLANK);

    // 100 with a dropped load of 42 three cycles in
    do_load(8'd100);
    repeat (2) @(negedge clk);
    bus.value = 8'd42;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    wait_idle("t4", c_SEG7, c_BLANK, c_BLANK, cyc);
    check("t4_busy_rest", cyc, 5);
    @(negedge clk);
    check("t4_not_queued", bus.busy, 0);
    check_display("t4", c_SEG0, c_SEG0, c_SEG1);

    // 0, then reload on the busy-falling cycle
    do_load(8'd0);
    wait_idle("t5a", c_SEG0, c_SEG0, c_SEG1, cyc);
    check("t5a_busy_cycles", cyc, 8);
    bus.value = 8'd0;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    check("t5_reaccept", bus.busy, 1);
    wait_idle("t5b", c_SEG0, c_BLANK, c_BLANK, cyc);
    check("t5b_busy_cycles", cyc, 8);
    check_display("t5", c_SEG0, c_BLANK, c_BLANK);

    // Reset mid-conversion of 200 after showing 99
    do_load(8'd99);
    wait_idle("t6a", c_SEG0, c_BLANK, c_BLANK, cyc);
    check_display("t6a", c_SEG9, c_SEG9, c_BLANK);
    do_load(8'd200);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_an", bus.an, 3'b110);
    check("t6_rst_seg", bus.seg, c_SEG0);
    @(negedge clk);
    rst_n = 1'b1;
    check_display("t6_rst", c_SEG0, c_BLANK, c_BLANK);
    check("t6_idle", bus.busy, 0);
    do_load(8'd9);
    wait_idle("t6b", c_SEG0, c_BLANK, c_BLANK, cyc);
    check("t6b_busy_cycles", cyc, 8);
    check_display("t6b", c_SEG9, c_BLANK, c_BLANK);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
